fsmd_driver: RTL
================

# fsmd_driver

Host-side sequencer for the `fsmd` processor block: accepts a command carrying `N_OPS` 16-bit operands, parks and restarts the FSMD, feeds each operand on the FSMD's `ext_in` as the FSMD requests it, and collects the value on `ext_out` when `done_out` rises. The result is returned with an error code over a valid/ready handshake. It sits between a command source (testbench, bus bridge) and one `fsmd` instance, driving that instance's `srst`.

## Interface
Parameters:
- `N_OPS`, default 2: operands per job, ≥1; operand k occupies `ops_in[16k+15:16k]`; operand 0 is fed first.
- `TIMEOUT_CYCLES`, default 1024: maximum cycles without FSMD progress before the job aborts; ≥2.

Ports:
- `clk`  in  1: single clock, rising edge.
- `arst_n`  in  1: asynchronous, active-low reset.
- `cmd_valid_in`  in  1: command offered.
- `cmd_ready_out`  out  1: driver idle, command accepted when both are high.
- `ops_in`  in  16*N_OPS: operands, sampled at accept.
- `fsmd_srst_out`  out  1: drives `fsmd.srst`.
- `fsmd_ext_in_out`  out  16: drives `fsmd.ext_in`.
- `fsmd_ready_in`  in  1: from `fsmd.ready_out`; high means the FSMD samples `ext_in` at this edge.
- `fsmd_done_in`  in  1: from `fsmd.done_out`.
- `fsmd_ext_out_in`  in  16: from `fsmd.ext_out`.
- `res_valid_out`  out  1: result available.
- `res_ready_in`  in  1: consumer takes result.
- `res_data_out`  out  16: captured `ext_out`, or 0 on timeout.
- `res_err_out`  out  2: 00 ok, 01 timeout, 10 overrun.

## Operation
- States: IDLE, FEED, WAIT_DONE, RESULT.
- IDLE: `cmd_ready_out`=1 and `fsmd_srst_out`=1, so the FSMD is held in its start state. On `cmd_valid_in`: latch `ops_in`, clear the index and timer, and go to FEED.
- FEED: `fsmd_ext_in_out` = operand[idx]. On `fsmd_ready_in`:
  - idx==N_OPS-1: go to WAIT_DONE.
  - Otherwise: idx+1.
  - In both cases the timer clears.
- WAIT_DONE: `fsmd_ext_in_out`=0. On `fsmd_done_in`, capture `fsmd_ext_out_in` and go to RESULT. Each `fsmd_ready_in` seen here sets a sticky overrun flag, because the FSMD wanted more than N_OPS operands; progress does not clear the timer.
- RESULT: `res_valid_out`=1. Data and error are held stable until `res_ready_in`, then go to IDLE. The FSMD is not reset here.
- Done seen in FEED means the FSMD used fewer operands. This is treated as completion: capture data, err 00, go to RESULT.
- Error code:
  - 10 if the overrun flag is set at completion.
  - 01 on timeout, with data forced to 0.
  - Timeout takes precedence over overrun.
- Timer:
  - Increments every FEED/WAIT_DONE cycle with no event.
  - At TIMEOUT_CYCLES-1 with no event in that cycle, go to RESULT with err 01.
  - Width is clog2(TIMEOUT_CYCLES+1).
- Same-cycle priority: done > ready > timeout.
- All registered state and outputs are reset by `arst_n` low, immediately, from any state. This includes mid-job: the job is lost, and the FSMD is re-held via `fsmd_srst_out`=1.

## Timing
- Reset values:
  - state IDLE, so `cmd_ready_out`=1 and `fsmd_srst_out`=1.
  - `res_valid_out`=0, `res_data_out`=0, `res_err_out`=00, `fsmd_ext_in_out`=0.
  - Internal index, timer and overrun flag are 0.
- `fsmd_srst_out` and `cmd_ready_out` decode from state. The FSMD sees srst high at the accept edge, so it starts cleanly in the first FEED cycle.
- Accept at edge E: operand 0 is on `fsmd_ext_in_out` from cycle E+1.
- Operand k stays stable until the edge where `fsmd_ready_in`=1. Operand k+1 appears in the next cycle.
- Done sampled at edge D: `res_valid_out`=1 in cycle D+1.
- Result consumed at edge R: IDLE in R+1; the next command may be accepted at edge R+1.
- Minimum job: 1 accept cycle + N_OPS ready cycles + 1 done cycle + 1 result cycle.
- Back-to-back ready pulses, one per cycle, are supported.

## Test plan
- GCD job on a real `fsmd` instance: ops 48,18 → one result with data 6, err 00; each ext_in value stable until its ready pulse.
- Bench FSMD model delaying ready by 0, 1 and 7 cycles per operand, ops 0x1234,0xBEEF → the model samples exactly 0x1234 then 0xBEEF; result 0xCAFE returned, err 00.
- Model never asserts done, TIMEOUT_CYCLES=16 → RESULT exactly 16 cycles after the last ready, data 0, err 01.
- Model issues 3 ready pulses with N_OPS=2, then done with 0x0042 → data 0x0042, err 10; ext_in=0 on the third pulse.
- Model asserts done after 1 operand → data captured, err 00, operand 1 never presented; `res_ready_in` held low 5 cycles → valid, data and err held stable.
- `arst_n` pulsed low mid-FEED, then a new command → all outputs at reset values during reset; new job completes with correct data, no residue of the aborted job.

Source files
------------

// File: rtl/fsmd_driver.sv
`default_nettype none
// ============================================================================
//  Module   : fsmd_driver
//  Purpose  : Host-side sequencer for one fsmd instance. Accepts a command
//             carrying N_OPS 16-bit operands, holds the FSMD in srst while
//             idle, feeds operands on ext_in as the FSMD asks for them and
//             returns ext_out (or an error) over a valid/ready handshake.
//  Ports    : clk, arst_n            - clock, async active-low reset
//             cmd_valid_in/_ready_out - command handshake, ops_in operands
//             fsmd_*                 - connections to the FSMD instance
//             res_valid_out/ready_in - result handshake
//             res_data_out/err_out   - result data, error (00 ok, 01 timeout,
//                                      10 overrun)
//  Revision : 1.0 - initial release
// ============================================================================
module fsmd_driver #(
  parameter int N_OPS          = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 cmd_valid_in,
  output logic                 cmd_ready_out,
  input  logic [16*N_OPS-1:0]  ops_in,
  output logic                 fsmd_srst_out,
  output logic [15:0]          fsmd_ext_in_out,
  input  logic                 fsmd_ready_in,
  input  logic                 fsmd_done_in,
  input  logic [15:0]          fsmd_ext_out_in,
  output logic                 res_valid_out,
  input  logic                 res_ready_in,
  output logic [15:0]          res_data_out,
  output logic [1:0]           res_err_out
);

  localparam int IDX_W = (N_OPS > 1) ? $clog2(N_OPS) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OPS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_OVERRUN = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_FEED      = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_RESULT    = 2'd3
  } state_e;

  state_e               state_q,    state_d;
  logic [IDX_W-1:0]     idx_q,      idx_d;
  logic [TMR_W-1:0]     tmr_q,      tmr_d;
  logic                 ovf_q,      ovf_d;
  logic [16*N_OPS-1:0]  ops_q,      ops_d;
  logic [15:0]          res_data_q, res_data_d;
  logic [1:0]           res_err_q,  res_err_d;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      tmr_q      <= '0;
      ovf_q      <= 1'b0;
      ops_q      <= '0;
      res_data_q <= '0;
      res_err_q  <= ERR_OK;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tmr_q      <= tmr_d;
      ovf_q      <= ovf_d;
      ops_q      <= ops_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Within FEED/WAIT_DONE the checks are ordered
  // done > ready > timeout so a same-cycle event always beats the timer.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tmr_d      = tmr_q;
    ovf_d      = ovf_q;
    ops_d      = ops_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_in) begin
          ops_d   = ops_in;
          idx_d   = '0;
          tmr_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_FEED;
        end
      end

      S_FEED: begin
        if (fsmd_done_in) begin
          // FSMD finished early: it simply needed fewer operands.
          res_data_d = fsmd_ext_out_in;
          res_err_d  = ERR_OK;
          state_d    = S_RESULT;
        end else if (fsmd_ready_in) begin
          tmr_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = S_WAIT_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (tmr_q == TMR_LAST) begin
          res_data_d = '0;
          res_err_d  = ERR_TIMEOUT;
          state_d    = S_RESULT;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      S_WAIT_DONE: begin
        if (fsmd_done_in) begin
          res_data_d = fsmd_ext_out_in;
          res_err_d  = ovf_q ? ERR_OVERRUN : ERR_OK;
          state_d    = S_RESULT;
        end else if (fsmd_ready_in) begin
          // Extra operand request: remember it, but it is not real progress,
          // so the timer is neither cleared nor advanced.
          ovf_d = 1'b1;
        end else if (tmr_q == TMR_LAST) begin
          res_data_d = '0;
          res_err_d  = ERR_TIMEOUT;
          state_d    = S_RESULT;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      S_RESULT: begin
        if (res_ready_in) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs decoded from state. Holding srst through the accept edge lets the
  // FSMD start from its initial state in the first FEED cycle.
  // --------------------------------------------------------------------------
  assign cmd_ready_out   = (state_q == S_IDLE);
  assign fsmd_srst_out   = (state_q == S_IDLE);
  assign res_valid_out   = (state_q == S_RESULT);
  assign fsmd_ext_in_out = (state_q == S_FEED) ? ops_q[16*idx_q +: 16] : 16'h0000;
  assign res_data_out    = res_data_q;
  assign res_err_out     = res_err_q;

endmodule
`default_nettype wire
